// File: rtl/out_img_capture.sv
// Captures CPU data-memory writes that land in the output-image window and
// streams them out as {offset, pixel} pairs through a small fall-through FIFO.
module out_img_capture #(
  parameter logic [31:0] BASE_ADDR  = 32'd262144,
  parameter int          IMG_PIXELS = 65536,
  parameter int          OFF_W      = 16,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          wr_en_i,
  input  logic [31:0]                   address_i,
  input  logic [31:0]                   data_i,
  input  logic                          clear_i,
  output logic                          pix_valid_o,
  output logic [OFF_W-1:0]              pix_offset_o,
  output logic [7:0]                    pix_data_o,
  input  logic                          pix_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
  output logic [OFF_W:0]                pixel_count_o,
  output logic                          overflow_o,
  output logic                          done_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ENT_W = OFF_W + 8;
  localparam logic [32:0]      WIN_END  = {1'b0, BASE_ADDR} + 33'(IMG_PIXELS);
  localparam logic [OFF_W:0]   CNT_MAX  = (OFF_W+1)'(IMG_PIXELS);
  localparam logic [PTR_W:0]   LVL_FULL = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   LVL_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [OFF_W:0]   CNT_ONE  = (OFF_W+1)'(1);

  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [PTR_W:0]   level, level_nxt;
  logic [OFF_W:0]   count, count_nxt;
  logic             overflow, overflow_nxt;
  logic             done, done_nxt;
  logic [ENT_W-1:0] head, last_head, new_entry;
  logic [31:0]      rel_addr;
  logic             hit, empty, full, push, pop;
  logic             unused_bits;

  // Stream handshake: an entry transfers at a rising edge where pix_valid_o
  // and pix_ready_i are both high; the head is held unchanged until then, and
  // pix_valid_o depends only on registered occupancy, never on pix_ready_i.
  always_comb begin
    rel_addr  = address_i - BASE_ADDR;
    hit       = wr_en_i && (address_i >= BASE_ADDR) && ({1'b0, address_i} < WIN_END);
    new_entry = {rel_addr[OFF_W-1:0], data_i[7:0]};
    empty     = (level == '0);
    full      = (level == LVL_FULL);
    pop       = !empty && pix_ready_i && !clear_i;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push      = hit && (!full || pop) && !clear_i;
  end

  always_comb begin
    wr_ptr_nxt   = wr_ptr;
    rd_ptr_nxt   = rd_ptr;
    level_nxt    = level;
    count_nxt    = count;
    overflow_nxt = overflow;
    if (clear_i) begin
      wr_ptr_nxt   = '0;
      rd_ptr_nxt   = '0;
      level_nxt    = '0;
      count_nxt    = '0;
      overflow_nxt = 1'b0;
    end else begin
      if (push) wr_ptr_nxt = wr_ptr + PTR_ONE;
      if (pop)  rd_ptr_nxt = rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   level_nxt = level + LVL_ONE;
        2'b01:   level_nxt = level - LVL_ONE;
        default: level_nxt = level;
      endcase
      if (push && (count != CNT_MAX)) count_nxt = count + CNT_ONE;
      if (hit && !push)               overflow_nxt = 1'b1;
    end
    done_nxt = (count_nxt == CNT_MAX) && (level_nxt == '0);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      count    <= '0;
      overflow <= 1'b0;
      done     <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr_nxt;
      rd_ptr   <= rd_ptr_nxt;
      level    <= level_nxt;
      count    <= count_nxt;
      overflow <= overflow_nxt;
      done     <= done_nxt;
    end
  end

  // Storage needs no reset: nothing is visible until the level says so.
  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  // Remembers the last presented head so the outputs hold once drained.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)        last_head <= '0;
    else if (!empty) last_head <= head;
  end

  assign head                        = mem[rd_ptr];
  assign pix_valid_o                 = !empty;
  assign {pix_offset_o, pix_data_o}  = empty ? last_head : head;
  assign fifo_level_o                = level;
  assign pixel_count_o               = count;
  assign overflow_o                  = overflow;
  assign done_o                      = done;
  assign unused_bits                 = ^{data_i[31:8], rel_addr[31:OFF_W]};

endmodule

// File: tb/tb_out_img_capture.sv
// Bench for out_img_capture: a scoreboard of expected {offset, pixel} pairs
// plus a small occupancy/count model; a second 16-pixel instance covers frame done.
module tb_out_img_capture;

  localparam int          OFF_W = 16;
  localparam int          DEPTH = 16;
  localparam int          W     = OFF_W + 8;
  localparam logic [31:0] BASE  = 32'd262144;
  localparam logic [31:0] WIN   = 32'd65536;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] address = '0;
  logic [31:0] data = '0;
  logic        clear = 1'b0;
  logic        ready = 1'b0;

  logic              valid, ovf, done;
  logic [OFF_W-1:0]  offset;
  logic [7:0]        pdata;
  logic [4:0]        level;
  logic [OFF_W:0]    count;

  logic              s_valid, s_ovf, s_done;
  logic [3:0]        s_offset;
  logic [7:0]        s_data;
  logic [4:0]        s_level;
  logic [4:0]        s_count;

  out_img_capture dut (
    .CLK(CLK), .RST(RST), .wr_en_i(wr_en), .address_i(address), .data_i(data),
    .clear_i(clear), .pix_valid_o(valid), .pix_offset_o(offset), .pix_data_o(pdata),
    .pix_ready_i(ready), .fifo_level_o(level), .pixel_count_o(count),
    .overflow_o(ovf), .done_o(done)
  );

  out_img_capture #(.IMG_PIXELS(16), .OFF_W(4)) dut_small (
    .CLK(CLK), .RST(RST), .wr_en_i(wr_en), .address_i(address), .data_i(data),
    .clear_i(clear), .pix_valid_o(s_valid), .pix_offset_o(s_offset), .pix_data_o(s_data),
    .pix_ready_i(ready), .fifo_level_o(s_level), .pixel_count_o(s_count),
    .overflow_o(s_ovf), .done_o(s_done)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  // scoreboard and model
  logic [W-1:0] exp_q[$];
  int           m_count = 0;
  logic         m_ovf = 1'b0;
  int           n_checks = 0;
  int           n_fail = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, expv);
    end
  endtask

  task automatic check_state(input string tag);
    check({tag, "_valid"}, 32'(valid), 32'(exp_q.size() > 0));
    check({tag, "_level"}, 32'(level), 32'(exp_q.size()));
    check({tag, "_count"}, 32'(count), 32'(m_count));
    check({tag, "_ovf"},   32'(ovf),   32'(m_ovf));
    check({tag, "_done"},  32'(done),  32'd0);
  endtask

  // One clock of stimulus: drive after a falling edge, check pops, update model.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d,
                      input logic rdy, input logic clr);
    logic         hit, pop;
    logic [W-1:0] e;
    logic [31:0]  rel;
    wr_en = we; address = a; data = d; ready = rdy; clear = clr;
    #1;
    hit = we && (a >= BASE) && (a < BASE + WIN);
    pop = (exp_q.size() > 0) && rdy && !clr;
    if (pop) begin
      if (!valid) begin
        n_checks++; n_fail++;
        $display("FAIL pop_valid: got 0, expected 1");
        e = exp_q.pop_front();
      end else begin
        e = exp_q.pop_front();
        check("pop_offset", 32'(offset), 32'(e[W-1:8]));
        check("pop_data",   32'(pdata),  32'(e[7:0]));
      end
    end
    if (clr) begin
      exp_q.delete();
      m_count = 0;
      m_ovf   = 1'b0;
    end else if (hit) begin
      if (exp_q.size() < DEPTH) begin
        rel = a - BASE;
        exp_q.push_back({rel[OFF_W-1:0], d[7:0]});
        if (m_count < int'(WIN)) m_count++;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'd0, 32'd0, rdy, 1'b0);
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  d;

    repeat (2) @(negedge CLK);
    check("rst_valid",   32'(valid),    32'd0);
    check("rst_offset",  32'(offset),   32'd0);
    check("rst_data",    32'(pdata),    32'd0);
    check("rst_level",   32'(level),    32'd0);
    check("rst_count",   32'(count),    32'd0);
    check("rst_ovf",     32'(ovf),      32'd0);
    check("rst_done",    32'(done),     32'd0);
    check("rst_s_done",  32'(s_done),   32'd0);
    RST = 1'b1;
    @(negedge CLK);

    // single hit, one-cycle latency, then pop and hold of last value
    step(1'b1, BASE + 32'd5, 32'hAB, 1'b1, 1'b0);
    check("single_valid",  32'(valid),  32'd1);
    check("single_offset", 32'(offset), 32'd5);
    check("single_data",   32'(pdata),  32'hAB);
    idle(1'b1);
    check_state("single_after");
    check("single_count",  32'(count),  32'd1);
    check("hold_offset",   32'(offset), 32'd5);
    check("hold_data",     32'(pdata),  32'hAB);

    // window filter
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    step(1'b1, 32'd100, 32'h11, 1'b1, 1'b0);
    step(1'b1, BASE - 32'd1, 32'h22, 1'b1, 1'b0);
    step(1'b1, BASE + WIN, 32'h33, 1'b1, 1'b0);
    check("filter_valid", 32'(valid), 32'd0);
    check("filter_count", 32'(count), 32'd0);
    check_state("filter");

    // backpressure and overflow: 17 hits, 16 fit
    for (int i = 0; i < 17; i++) step(1'b1, BASE + 32'(i), 32'($urandom_range(0, 255)), 1'b0, 1'b0);
    check("ovf_level", 32'(level), 32'd16);
    check("ovf_flag",  32'(ovf),   32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check_state("ovf");
    for (int i = 0; i < 16; i++) idle(1'b1);
    check_state("ovf_drained");

    // full FIFO with a simultaneous push and pop
    step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, BASE + 32'(100 + i), 32'(i), 1'b0, 1'b0);
    step(1'b1, BASE + 32'd200, 32'h5C, 1'b1, 1'b0);
    check("full_pp_level", 32'(level), 32'd16);
    check("full_pp_ovf",   32'(ovf),   32'd0);
    check_state("full_pp");
    for (int i = 0; i < 16; i++) idle(1'b1);
    check_state("full_pp_drained");

    // random traffic against the scoreboard
    for (int i = 0; i < 200; i++) begin
      case ($urandom_range(0, 4))
        0, 1:    a = BASE + 32'($urandom_range(0, 65535));
        2:       a = BASE - 32'd1 - 32'($urandom_range(0, 100));
        3:       a = BASE + WIN + 32'($urandom_range(0, 100));
        default: a = 32'($urandom_range(0, 4095));
      endcase
      d = 8'($urandom_range(0, 255));
      step(1'($urandom_range(0, 3) != 0), a, {24'($urandom), d}, 1'($urandom_range(0, 9) < 6), 1'b0);
    end
    for (int i = 0; i < 20; i++) idle(1'b1);
    check_state("random_drained");

    // frame done on the 16-pixel instance, saturation, clear beats a hit
    step(1'b0, 32'd0, 32'd0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, BASE + 32'(i), 32'($urandom_range(0, 255)), 1'b1, 1'b0);
    check("frame_pre_done",  32'(s_done),  32'd0);
    check("frame_pre_count", 32'(s_count), 32'd16);
    check("frame_pre_level", 32'(s_level), 32'd1);
    idle(1'b1);
    check("frame_done",       32'(s_done),  32'd1);
    check("frame_done_level", 32'(s_level), 32'd0);
    check("frame_done_valid", 32'(s_valid), 32'd0);
    step(1'b1, BASE + 32'd2, 32'h5A, 1'b1, 1'b0);
    check("sat_count", 32'(s_count), 32'd16);
    check("sat_done",  32'(s_done),  32'd0);
    check("sat_level", 32'(s_level), 32'd1);
    idle(1'b1);
    check("sat_redone", 32'(s_done), 32'd1);
    step(1'b1, BASE + 32'd3, 32'h11, 1'b1, 1'b1);
    check("clr_count", 32'(s_count), 32'd0);
    check("clr_done",  32'(s_done),  32'd0);
    check("clr_valid", 32'(s_valid), 32'd0);
    check("clr_level", 32'(s_level), 32'd0);
    check("clr_ovf",   32'(s_ovf),   32'd0);
    check_state("clr_main");

    // async reset with 5 entries queued and overflow set
    for (int i = 1; i <= 17; i++) step(1'b1, BASE + 32'(i), 32'(8'h80 | 8'(i)), 1'b0, 1'b0);
    for (int i = 0; i < 11; i++) idle(1'b1);
    check_state("pre_reset");
    check("pre_reset_level", 32'(level), 32'd5);
    wr_en = 1'b0; ready = 1'b0; clear = 1'b0;
    #2;
    RST = 1'b0;
    #1;
    check("areset_valid",  32'(valid),  32'd0);
    check("areset_offset", 32'(offset), 32'd0);
    check("areset_data",   32'(pdata),  32'd0);
    check("areset_level",  32'(level),  32'd0);
    check("areset_count",  32'(count),  32'd0);
    check("areset_ovf",    32'(ovf),    32'd0);
    check("areset_done",   32'(done),   32'd0);
    check("areset_s_cnt",  32'(s_count), 32'd0);
    exp_q.delete();
    m_count = 0;
    m_ovf   = 1'b0;
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    step(1'b1, BASE + 32'd9, 32'h3C, 1'b1, 1'b0);
    idle(1'b1);
    check_state("post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
